uart_rx_framer: RTL and testbench
=================================

# uart_rx_framer

Receive-side frame parser between the UART receive FIFO read port and the packet consumer, clocked on the parallel clock. It pulls bytes from the FIFO with a valid/ready handshake, hunts for a start-of-frame byte, checks length, parity-error flags and checksum, and streams payload bytes downstream. Each frame ends with a one-cycle done or error pulse, and the block keeps good/bad frame counters.

## Interface
- `SOF`, 8'h7E: start-of-frame byte.
- `MAX_LEN`, 16: maximum payload length in bytes, legal range 1..255.
- `pclk_i` in 1: single clock. Everything is on the posedge.
- `prst_n_i` in 1: reset, asynchronous and active-low.
- `rx_pdata_i` in 8: byte from the receive FIFO.
- `rx_pdata_valid_i` in 1: FIFO read data valid.
- `rx_pdata_err_i` in 1: parity-error flag travelling with `rx_pdata_i`.
- `rx_read_ready_o` out 1: framer can accept a FIFO byte this cycle.
- `frm_data_o` out 8: payload byte.
- `frm_data_valid_o` out 1: payload byte valid.
- `frm_data_ready_i` in 1: downstream accepts the payload byte.
- `frm_last_o` out 1: marks the final payload byte of a frame. Qualified by `frm_data_valid_o`.
- `frm_done_o` out 1: one-cycle pulse when a frame is good.
- `frm_err_o` out 1: one-cycle pulse when a frame is aborted or bad.
- `err_code_o` out 2: error code, valid with `frm_err_o`. 1 = parity, 2 = length, 3 = checksum. Holds its last value otherwise.
- `good_cnt_o` out 16: count of good frames. Wraps.
- `bad_cnt_o` out 8: count of errored frames. Saturates at 255.

## Operation
- Frame format is SOF, LEN, LEN payload bytes, CSUM.
  - A frame is good when (LEN + Σpayload + CSUM) mod 256 == 0.
  - There is no escaping. SOF inside a frame is ordinary data.
- A byte is accepted on any cycle where `rx_pdata_valid_i && rx_read_ready_o`.
- FSM states: HUNT, LEN, PAY, CSUM.
- HUNT:
  - Accepts and discards every byte except an error-free SOF.
  - An error-free SOF moves to LEN.
  - A SOF carrying `rx_pdata_err_i` is discarded and does not count as an error.
- LEN:
  - `rx_pdata_err_i` high → error code 1, go to HUNT.
  - LEN == 0 or LEN > `MAX_LEN` → error code 2, go to HUNT.
  - Otherwise load the remaining-byte counter with LEN, seed the checksum accumulator with LEN, go to PAY.
- PAY:
  - Each accepted byte is written to the one-entry output register, added to the accumulator (8-bit wrap), and decrements the counter.
  - When the counter reaches 0 (the LEN-th byte), `frm_last_o` is set with that byte and the FSM goes to CSUM.
  - `rx_pdata_err_i` high → the byte is dropped (not forwarded), error code 1, go to HUNT.
- CSUM:
  - `rx_pdata_err_i` high → error code 1.
  - Otherwise, accumulator + byte ≠ 0 → error code 3.
  - Otherwise pulse `frm_done_o`.
  - Always go to HUNT.
- Every error pulses `frm_err_o` once and increments `bad_cnt_o`. Every `frm_done_o` increments `good_cnt_o`.
- Payload bytes already forwarded are not recalled on a later error. Downstream discards the frame on `frm_err_o`.
- `rx_read_ready_o`:
  - HUNT, LEN, CSUM: 1.
  - PAY: `!frm_data_valid_o || frm_data_ready_i`.

## Timing
- Reset values: `rx_read_ready_o`=1, `frm_data_o`=0, `frm_data_valid_o`=0, `frm_last_o`=0, `frm_done_o`=0, `frm_err_o`=0, `err_code_o`=0, `good_cnt_o`=0, `bad_cnt_o`=0. FSM resets to HUNT; counter and accumulator reset to 0.
- A payload byte accepted in cycle N appears on `frm_data_o` in cycle N+1. Throughput is one byte per cycle when `frm_data_ready_i` is held high.
- `frm_data_o`, `frm_data_valid_o` and `frm_last_o` hold stable while valid is high and ready is low.
- Simultaneous drain and fill in PAY: the register reloads in the same cycle and valid stays high.
- `frm_done_o` / `frm_err_o` pulse in the cycle after the deciding byte is accepted. The pulse is independent of whether the output register has drained, so done may coincide with last still pending.
- Reset asserted mid-frame clears everything immediately, including any pending output byte, with no pulse. After reset the block hunts for SOF.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum (HUNT, LEN, PAY, CSUM);
  - error code constants (ERR_PARITY=1, ERR_LEN=2, ERR_CSUM=3);
  - the default SOF constant.
- One sub-module, `uart_out_reg`: a one-entry valid/ready output register carrying 9 bits (data + last), with `in_ready = !valid || out_ready`.
- FSM, counter, accumulator and statistics counters live in the top of `uart_rx_framer`.

## Test plan
- Feed 55 7E 03 11 22 33 97 with ready held 1:
  - 55 is discarded;
  - payload 11, 22, 33 appears on consecutive cycles, with last on 33;
  - `frm_done_o` pulses once and `good_cnt_o`=1.
- Same frame with CSUM 98 → payload forwarded, `frm_err_o` pulses with `err_code_o`=3, `bad_cnt_o`=1.
- 7E 00, then 7E 11 (MAX_LEN=16) → two pulses with code 2; no payload forwarded; `bad_cnt_o`=2.
- 7E 02 AA BB with `rx_pdata_err_i`=1 on BB → AA is forwarded, BB is not; code 1 pulse; the framer returns to HUNT and parses a following good frame correctly.
- Good 4-byte frame with `frm_data_ready_i` toggling 1/0 → `rx_read_ready_o` drops while the register is full, data is held stable, no byte is lost or duplicated, and done pulses.
- Assert `prst_n_i` low after 7E 03 11 → all outputs return to reset values asynchronously; a subsequent full good frame gives `good_cnt_o`=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive framer.
package uart_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LEN  = 2'd1,
        PAY  = 2'd2,
        CSUM = 2'd3
    } state_t;

    localparam logic [1:0] ERR_PARITY  = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_CSUM    = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'h7E;

endpackage

// File: rtl/uart_out_reg.sv
// One-entry valid/ready output register carrying a payload byte plus its last flag.
module uart_out_reg (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [8:0] i_data,
    output logic       o_ready,
    output logic       o_valid,
    output logic [8:0] o_data,
    input  logic       i_ready
);

    logic       r_valid;
    logic [8:0] r_data;

    // Accept whenever the slot is empty or is being drained this cycle.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= 9'd0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// Receive frame parser: SOF, LEN, payload, CSUM; streams payload and keeps good/bad frame statistics.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter logic [7:0] SOF     = SOF_DEFAULT,
    parameter int         MAX_LEN = 16
) (
    input  logic        pclk_i,
    input  logic        prst_n_i,
    input  logic [7:0]  rx_pdata_i,
    input  logic        rx_pdata_valid_i,
    input  logic        rx_pdata_err_i,
    output logic        rx_read_ready_o,
    output logic [7:0]  frm_data_o,
    output logic        frm_data_valid_o,
    input  logic        frm_data_ready_i,
    output logic        frm_last_o,
    output logic        frm_done_o,
    output logic        frm_err_o,
    output logic [1:0]  err_code_o,
    output logic [15:0] good_cnt_o,
    output logic [7:0]  bad_cnt_o
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_acc;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic [15:0] r_good_cnt;
    logic [7:0]  r_bad_cnt;

    logic        w_accept;
    logic        w_push;
    logic        w_in_ready;
    logic [7:0]  w_sum;
    logic        w_fail;
    logic        w_good;
    logic [1:0]  w_code;
    logic [8:0]  w_out_data;

    assign w_accept        = rx_pdata_valid_i && rx_read_ready_o;
    assign w_sum           = r_acc + rx_pdata_i;
    assign rx_read_ready_o = (r_state != PAY) || w_in_ready;
    // Parity-flagged payload bytes are never forwarded.
    assign w_push          = w_accept && (r_state == PAY) && !rx_pdata_err_i;

    always_comb begin
        w_fail = 1'b0;
        w_good = 1'b0;
        w_code = r_err_code;
        if (w_accept) begin
            case (r_state)
                LEN: begin
                    if (rx_pdata_err_i) begin
                        w_fail = 1'b1;
                        w_code = ERR_PARITY;
                    end else if (rx_pdata_i == 8'd0 || rx_pdata_i > MAX_LEN_B) begin
                        w_fail = 1'b1;
                        w_code = ERR_LEN;
                    end
                end
                PAY: begin
                    if (rx_pdata_err_i) begin
                        w_fail = 1'b1;
                        w_code = ERR_PARITY;
                    end
                end
                CSUM: begin
                    if (rx_pdata_err_i) begin
                        w_fail = 1'b1;
                        w_code = ERR_PARITY;
                    end else if (w_sum != 8'd0) begin
                        w_fail = 1'b1;
                        w_code = ERR_CSUM;
                    end else begin
                        w_good = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            r_state    <= HUNT;
            r_cnt      <= 8'd0;
            r_acc      <= 8'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_good_cnt <= 16'd0;
            r_bad_cnt  <= 8'd0;
        end else begin
            r_done <= w_good;
            r_err  <= w_fail;
            if (w_fail) begin
                r_err_code <= w_code;
                if (r_bad_cnt != 8'hFF) begin
                    r_bad_cnt <= r_bad_cnt + 8'd1;
                end
            end
            if (w_good) begin
                r_good_cnt <= r_good_cnt + 16'd1;
            end
            if (w_fail || w_good) begin
                r_state <= HUNT;
            end else if (w_accept) begin
                case (r_state)
                    HUNT: begin
                        if (rx_pdata_i == SOF && !rx_pdata_err_i) begin
                            r_state <= LEN;
                        end
                    end
                    LEN: begin
                        r_cnt   <= rx_pdata_i;
                        r_acc   <= rx_pdata_i;
                        r_state <= PAY;
                    end
                    PAY: begin
                        r_acc <= w_sum;
                        r_cnt <= r_cnt - 8'd1;
                        if (r_cnt == 8'd1) begin
                            r_state <= CSUM;
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign w_out_data = {(r_cnt == 8'd1), rx_pdata_i};

    uart_out_reg u_out_reg (
        .i_clk   (pclk_i),
        .i_rst_n (prst_n_i),
        .i_valid (w_push),
        .i_data  (w_out_data),
        .o_ready (w_in_ready),
        .o_valid (frm_data_valid_o),
        .o_data  ({frm_last_o, frm_data_o}),
        .i_ready (frm_data_ready_i)
    );

    assign frm_done_o = r_done;
    assign frm_err_o  = r_err;
    assign err_code_o = r_err_code;
    assign good_cnt_o = r_good_cnt;
    assign bad_cnt_o  = r_bad_cnt;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed testbench for uart_rx_framer: byte streams in, payload/pulse/counter checks out.
module tb_uart_rx_framer;

    logic        pclk = 1'b0;
    logic        prst_n_i = 1'b0;
    logic [7:0]  rx_pdata_i = 8'd0;
    logic        rx_pdata_valid_i = 1'b0;
    logic        rx_pdata_err_i = 1'b0;
    logic        rx_read_ready_o;
    logic [7:0]  frm_data_o;
    logic        frm_data_valid_o;
    logic        frm_data_ready_i = 1'b1;
    logic        frm_last_o;
    logic        frm_done_o;
    logic        frm_err_o;
    logic [1:0]  err_code_o;
    logic [15:0] good_cnt_o;
    logic [7:0]  bad_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] rx_q[$];
    int         rx_cyc[$];
    logic [1:0] err_q[$];
    int         done_cnt = 0;
    bit         saw_stall = 0;
    bit         toggle_en = 0;
    logic       hold_valid = 1'b0;
    logic [8:0] hold_data = 9'd0;
    int         cyc = 0;

    logic [7:0] fb[$];
    logic [8:0] ep[$];

    uart_rx_framer #(.SOF(8'h7E), .MAX_LEN(16)) dut (
        .pclk_i           (pclk),
        .prst_n_i         (prst_n_i),
        .rx_pdata_i       (rx_pdata_i),
        .rx_pdata_valid_i (rx_pdata_valid_i),
        .rx_pdata_err_i   (rx_pdata_err_i),
        .rx_read_ready_o  (rx_read_ready_o),
        .frm_data_o       (frm_data_o),
        .frm_data_valid_o (frm_data_valid_o),
        .frm_data_ready_i (frm_data_ready_i),
        .frm_last_o       (frm_last_o),
        .frm_done_o       (frm_done_o),
        .frm_err_o        (frm_err_o),
        .err_code_o       (err_code_o),
        .good_cnt_o       (good_cnt_o),
        .bad_cnt_o        (bad_cnt_o)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge pclk) begin
        cyc++;
        #2;
        if (toggle_en) frm_data_ready_i = ~frm_data_ready_i;
    end

    // Observe on the falling edge, where inputs and outputs are both settled.
    always @(negedge pclk) begin
        if (prst_n_i) begin
            if (hold_valid)
                chk("hold", {frm_data_valid_o, frm_last_o, frm_data_o}, {1'b1, hold_data});
            if (frm_data_valid_o && frm_data_ready_i) begin
                rx_q.push_back({frm_last_o, frm_data_o});
                rx_cyc.push_back(cyc);
                $display("payload: data=%02h last=%0d", frm_data_o, frm_last_o);
            end
            hold_valid = frm_data_valid_o && !frm_data_ready_i;
            hold_data  = {frm_last_o, frm_data_o};
            if (frm_data_valid_o && !rx_read_ready_o) saw_stall = 1;
            if (frm_done_o) begin
                done_cnt++;
                $display("done: good_cnt=%0d", good_cnt_o);
            end
            if (frm_err_o) begin
                err_q.push_back(err_code_o);
                $display("error: code=%0d", err_code_o);
            end
        end else begin
            hold_valid = 1'b0;
        end
    end

    task automatic clear_obs();
        rx_q.delete();
        rx_cyc.delete();
        err_q.delete();
        done_cnt  = 0;
        saw_stall = 0;
    endtask

    // Called at posedge+2; returns at posedge+2 right after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input logic e);
        int k;
        rx_pdata_i       = b;
        rx_pdata_err_i   = e;
        rx_pdata_valid_i = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge pclk);
            if (rx_read_ready_o) break;
        end
        if (k == 50) chk("accept_timeout", {31'd0, rx_read_ready_o}, 32'd1);
        @(posedge pclk);
        #2;
    endtask

    task automatic send_frame(input int err_idx);
        @(posedge pclk);
        #2;
        $display("frame: %0d bytes, err at %0d", fb.size(), err_idx);
        foreach (fb[i]) send_byte(fb[i], (i == err_idx));
        rx_pdata_valid_i = 1'b0;
        rx_pdata_err_i   = 1'b0;
    endtask

    task automatic chk_payload(input string tag);
        chk({tag, "_n"}, rx_q.size(), ep.size());
        foreach (ep[i])
            if (i < rx_q.size()) chk(tag, {23'd0, rx_q[i]}, {23'd0, ep[i]});
    endtask

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_ready", {31'd0, rx_read_ready_o}, 32'd1);
        chk("rst_valid", {31'd0, frm_data_valid_o}, 32'd0);
        chk("rst_data", {24'd0, frm_data_o}, 32'd0);
        chk("rst_cnts", {8'd0, good_cnt_o, bad_cnt_o}, 32'd0);
        chk("rst_pulses", {28'd0, frm_done_o, frm_err_o, err_code_o}, 32'd0);
        @(posedge pclk);
        #2;
        prst_n_i = 1'b1;

        // Good frame preceded by junk.
        clear_obs();
        fb = '{8'h55, 8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_frame(-1);
        repeat (4) @(posedge pclk);
        ep = '{9'h011, 9'h022, 9'h133};
        chk_payload("t1_pay");
        if (rx_cyc.size() == 3) chk("t1_consec", rx_cyc[2] - rx_cyc[0], 2);
        chk("t1_done", done_cnt, 1);
        chk("t1_errs", err_q.size(), 0);
        chk("t1_good", {16'd0, good_cnt_o}, 32'd1);

        // Bad checksum.
        clear_obs();
        fb = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
        send_frame(-1);
        repeat (4) @(posedge pclk);
        chk_payload("t2_pay");
        chk("t2_nerr", err_q.size(), 1);
        if (err_q.size() > 0) chk("t2_code", {30'd0, err_q[0]}, 32'd3);
        chk("t2_hold_code", {30'd0, err_code_o}, 32'd3);
        chk("t2_done", done_cnt, 0);
        chk("t2_bad", {24'd0, bad_cnt_o}, 32'd1);

        // Zero and oversize length.
        clear_obs();
        fb = '{8'h7E, 8'h00, 8'h7E, 8'h11};
        send_frame(-1);
        repeat (4) @(posedge pclk);
        ep = {};
        chk_payload("t3_pay");
        chk("t3_nerr", err_q.size(), 2);
        foreach (err_q[i]) chk("t3_code", {30'd0, err_q[i]}, 32'd2);
        chk("t3_bad", {24'd0, bad_cnt_o}, 32'd3);

        // Parity error mid-payload, then a good frame.
        clear_obs();
        fb = '{8'h7E, 8'h02, 8'hAA, 8'hBB};
        send_frame(3);
        repeat (4) @(posedge pclk);
        ep = '{9'h0AA};
        chk_payload("t4_pay");
        chk("t4_nerr", err_q.size(), 1);
        if (err_q.size() > 0) chk("t4_code", {30'd0, err_q[0]}, 32'd1);
        chk("t4_bad", {24'd0, bad_cnt_o}, 32'd4);
        clear_obs();
        fb = '{8'h7E, 8'h01, 8'h55, 8'hAA};
        send_frame(-1);
        repeat (4) @(posedge pclk);
        ep = '{9'h155};
        chk_payload("t4b_pay");
        chk("t4b_done", done_cnt, 1);
        chk("t4b_good", {16'd0, good_cnt_o}, 32'd2);

        // Downstream backpressure toggling every cycle.
        clear_obs();
        toggle_en = 1;
        fb = '{8'h7E, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
        send_frame(-1);
        repeat (10) @(posedge pclk);
        toggle_en = 0;
        #3;
        frm_data_ready_i = 1'b1;
        repeat (3) @(posedge pclk);
        ep = '{9'h001, 9'h002, 9'h003, 9'h104};
        chk_payload("t5_pay");
        chk("t5_stall", {31'd0, saw_stall}, 32'd1);
        chk("t5_done", done_cnt, 1);
        chk("t5_good", {16'd0, good_cnt_o}, 32'd3);

        // Asynchronous reset mid-frame with a byte pending.
        clear_obs();
        @(posedge pclk);
        #2;
        frm_data_ready_i = 1'b0;
        fb = '{8'h7E, 8'h03, 8'h11};
        send_frame(-1);
        repeat (2) @(posedge pclk);
        #4;
        chk("t6_pre_valid", {31'd0, frm_data_valid_o}, 32'd1);
        prst_n_i = 1'b0;
        #1;
        chk("t6_valid", {31'd0, frm_data_valid_o}, 32'd0);
        chk("t6_data", {23'd0, frm_last_o, frm_data_o}, 32'd0);
        chk("t6_ready", {31'd0, rx_read_ready_o}, 32'd1);
        chk("t6_cnts", {8'd0, good_cnt_o, bad_cnt_o}, 32'd0);
        chk("t6_pulses", {28'd0, frm_done_o, frm_err_o, err_code_o}, 32'd0);
        repeat (2) @(posedge pclk);
        #2;
        prst_n_i = 1'b1;
        frm_data_ready_i = 1'b1;
        chk("t6_nopulse", err_q.size() + done_cnt, 0);
        clear_obs();
        fb = '{8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_frame(-1);
        repeat (4) @(posedge pclk);
        ep = '{9'h011, 9'h022, 9'h133};
        chk_payload("t6_pay");
        chk("t6_good", {16'd0, good_cnt_o}, 32'd1);
        chk("t6_done", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
